// File: rtl/wbs_wide_mem_bridge.sv
// Wishbone slave that pairs 32-bit bus halves into 64-bit single-port SRAM words.
// Optional WBS_ERR_CNT_EN adds err_count_o, counting orphan upper writes (clear by writing offset 0xFFF8).
module wbs_wide_mem_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h3002_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int          MEM_ADDR_WIDTH = 9,
    parameter int          MEM_DATA_WIDTH = 64
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    input  logic                      mem_grant_i,
    output logic                      mem_csb_o,
    output logic                      mem_web_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i
`ifdef WBS_ERR_CNT_EN
    ,
    output logic [7:0]                err_count_o
`endif
);

    typedef enum logic [2:0] {IDLE, WR_MEM, RD_MEM, RD_WAIT, ACK} state_t;

    state_t                    state, state_nxt;
    logic [31:0]               offset;
    logic                      hit, req, half, is_clr;
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic [31:0]               lo_hold, hi_hold, rd_data;
    logic                      lo_valid, wr_orphan, half_q;
    logic [MEM_ADDR_WIDTH-1:0] lo_idx, addr_q;
    logic                      unused_offset_bits;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++)
            if (sel[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        return res;
    endfunction

    assign offset             = wbs_adr_i - BASE_ADDR;
    assign hit                = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign req                = wbs_cyc_i & wbs_stb_i & hit;
    assign half               = offset[2];
    assign idx                = offset[MEM_ADDR_WIDTH+2:3];
    assign unused_offset_bits = ^{offset[31:MEM_ADDR_WIDTH+3], offset[1:0]};

`ifdef WBS_ERR_CNT_EN
    assign is_clr = (offset[15:2] == 14'h3FFE);
`else
    assign is_clr = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // lower-half writes only touch the holding register, so they skip the grant
                if (req) begin
                    if (wbs_we_i && !half) state_nxt = ACK;
                    else if (mem_grant_i)  state_nxt = wbs_we_i ? WR_MEM : RD_MEM;
                end
            end
            WR_MEM:  state_nxt = ACK;
            RD_MEM:  state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o   = (state == ACK);
        wbs_dat_o   = rd_data;
        mem_csb_o   = !((state == WR_MEM && !wr_orphan) || state == RD_MEM);
        mem_web_o   = !(state == WR_MEM && !wr_orphan);
        mem_addr_o  = addr_q;
        mem_wdata_o = {hi_hold, lo_hold};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lo_hold   <= '0;
            hi_hold   <= '0;
            lo_valid  <= 1'b0;
            lo_idx    <= '0;
            addr_q    <= '0;
            wr_orphan <= 1'b0;
            half_q    <= 1'b0;
            rd_data   <= '0;
`ifdef WBS_ERR_CNT_EN
            err_count_o <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req && wbs_we_i && !half) begin
                        if (is_clr) begin
`ifdef WBS_ERR_CNT_EN
                            err_count_o <= '0;
`endif
                        end else begin
                            lo_hold  <= merge_lanes(lo_hold, wbs_dat_i, wbs_sel_i);
                            lo_valid <= 1'b1;
                            lo_idx   <= idx;
                        end
                    end else if (req && wbs_we_i && mem_grant_i) begin
                        hi_hold   <= merge_lanes(hi_hold, wbs_dat_i, wbs_sel_i);
                        wr_orphan <= !(lo_valid && lo_idx == idx);
                        addr_q    <= idx;
                    end else if (req && mem_grant_i) begin
                        addr_q <= idx;
                        half_q <= half;
                    end
                end
                WR_MEM: begin
                    lo_valid <= 1'b0;
`ifdef WBS_ERR_CNT_EN
                    if (wr_orphan && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
`endif
                end
                RD_WAIT: rd_data <= half_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wbs_wide_mem_bridge.sv
// Self-checking bench for wbs_wide_mem_bridge: directed scenarios plus randomized traffic
// checked against a transaction-level model of the holding registers and memory contents.
module tb_wbs_wide_mem_bridge;

    localparam logic [31:0] BASE = 32'h3002_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we, grant;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        csb, web;
    logic [8:0]  maddr;
    logic [63:0] mwdata;
    logic [63:0] mrdata;
`ifdef WBS_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    always #5 clk = ~clk;

    wbs_wide_mem_bridge dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_dat_i  (dat_i),
        .wbs_adr_i  (adr),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .mem_grant_i(grant),
        .mem_csb_o  (csb),
        .mem_web_o  (web),
        .mem_addr_o (maddr),
        .mem_wdata_o(mwdata),
        .mem_rdata_i(mrdata)
`ifdef WBS_ERR_CNT_EN
        ,
        .err_count_o(err_count)
`endif
    );

    // SRAM with one-cycle read latency, plus a write monitor
    logic [63:0] sram    [512];
    logic [63:0] exp_mem [512];
    int          wr_cnt = 0;
    logic [8:0]  last_waddr;
    logic [63:0] last_wdata;

    always @(posedge clk) begin
        if (!rst && !csb) begin
            if (!web) begin
                sram[maddr] = mwdata;
                wr_cnt      = wr_cnt + 1;
                last_waddr  = maddr;
                last_wdata  = mwdata;
            end else begin
                mrdata <= sram[maddr];
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // transaction-level reference state
    logic [31:0] lo_m, hi_m;
    logic        lo_valid_m;
    logic [8:0]  lo_idx_m, exp_waddr;
    int          err_m;

    task automatic model_reset();
        lo_m = '0; hi_m = '0; lo_valid_m = 1'b0; lo_idx_m = '0; err_m = 0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output int exp_lat, output int exp_wr);
        logic [31:0] off, m;
        logic [8:0]  ix;
        logic        clr;
        off = a - BASE;
        ix  = off[11:3];
        m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        exp_wr = 0;
        clr = 1'b0;
`ifdef WBS_ERR_CNT_EN
        clr = (off[15:2] == 14'h3FFE);
`endif
        if (clr) begin
            err_m = 0;
            exp_lat = 1;
        end else if (!off[2]) begin
            lo_m = (lo_m & ~m) | (d & m);
            lo_valid_m = 1'b1;
            lo_idx_m = ix;
            exp_lat = 1;
        end else begin
            hi_m = (hi_m & ~m) | (d & m);
            exp_lat = 2;
            if (lo_valid_m && lo_idx_m == ix) begin
                exp_wr = 1;
                exp_mem[ix] = {hi_m, lo_m};
                exp_waddr = ix;
            end else if (err_m < 255) begin
                err_m++;
            end
            lo_valid_m = 1'b0;
        end
    endtask

    task automatic wb_start(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    endtask

    task automatic wait_ack(input int maxc, output int lat, output logic [31:0] rdat);
        lat = -1;
        rdat = '0;
        for (int n = 1; n <= maxc; n++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                lat = n;
                rdat = dat_o;
                break;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic run_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int el, ew, lat, w0;
        logic [31:0] rd;
        w0 = wr_cnt;
        model_write(a, d, s, el, ew);
        wb_start(1'b1, a, d, s);
        wait_ack(20, lat, rd);
        check_val({tag, "_lat"}, 64'(lat), 64'(el));
        check_val({tag, "_nwr"}, 64'(wr_cnt - w0), 64'(ew));
        if (ew == 1) begin
            check_val({tag, "_waddr"}, 64'(last_waddr), 64'(exp_waddr));
            check_val({tag, "_wdata"}, last_wdata, {hi_m, lo_m});
        end
    endtask

    task automatic run_read(input string tag, input logic [31:0] a);
        logic [31:0] off, rd, exp_d;
        int lat, w0;
        off = a - BASE;
        exp_d = off[2] ? exp_mem[off[11:3]][63:32] : exp_mem[off[11:3]][31:0];
        w0 = wr_cnt;
        wb_start(1'b0, a, 32'h0, 4'h0);
        wait_ack(20, lat, rd);
        check_val({tag, "_lat"}, 64'(lat), 64'd3);
        check_val({tag, "_data"}, 64'(rd), 64'(exp_d));
        check_val({tag, "_nwr"}, 64'(wr_cnt - w0), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ack"}, 64'(ack), 64'd0);
        check_val({tag, "_dat"}, 64'(dat_o), 64'd0);
        check_val({tag, "_csb_web"}, 64'({csb, web}), 64'd3);
        check_val({tag, "_addr"}, 64'(maddr), 64'd0);
        check_val({tag, "_wdata"}, mwdata, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0, ack_seen, csb_low, el, ew;
        logic [31:0] rd;
        logic [63:0] v;

        rst = 1'b1; grant = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; dat_i = '0; adr = '0;
        for (int i = 0; i < 512; i++) begin
            v = {$urandom, $urandom};
            sram[i] = v;
            exp_mem[i] = v;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // paired write to word 2
        run_write("tp_lo", BASE + 32'h10, 32'h0000_1234, 4'hF);
        run_write("tp_hi", BASE + 32'h14, 32'h00AB_CDEF, 4'hF);
        check_val("tp_wdata_const", last_wdata, 64'h00AB_CDEF_0000_1234);
        check_val("tp_waddr_const", 64'(last_waddr), 64'd2);

        // preloaded read of word 5, both halves
        sram[5] = 64'hDEAD_BEEF_CAFE_F00D;
        exp_mem[5] = 64'hDEAD_BEEF_CAFE_F00D;
        run_read("rd_lo", BASE + 32'h28);
        run_read("rd_hi", BASE + 32'h2C);

        // upper write stalls without grant
        run_write("gr_lo", BASE + 32'h18, 32'h5555_AAAA, 4'hF);
        grant = 1'b0;
        w0 = wr_cnt;
        model_write(BASE + 32'h1C, 32'h7777_8888, 4'hF, el, ew);
        wb_start(1'b1, BASE + 32'h1C, 32'h7777_8888, 4'hF);
        ack_seen = 0; csb_low = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ack) ack_seen++;
            if (!csb) csb_low++;
        end
        check_val("gr_stall_ack", 64'(ack_seen), 64'd0);
        check_val("gr_stall_csb", 64'(csb_low), 64'd0);
        @(negedge clk);
        grant = 1'b1;
        wait_ack(20, lat, rd);
        check_val("gr_lat", 64'(lat), 64'd2);
        check_val("gr_nwr", 64'(wr_cnt - w0), 64'(ew));
        check_val("gr_wdata", last_wdata, 64'h7777_8888_5555_AAAA);

        // orphan upper write (lower half already consumed)
        run_write("orph", BASE + 32'h1C, 32'h1357_9BDF, 4'hF);
`ifdef WBS_ERR_CNT_EN
        check_val("orph_cnt", 64'(err_count), 64'd1);
        run_write("clr", BASE + 32'hFFF8, 32'hFFFF_FFFF, 4'hF);
        check_val("clr_cnt", 64'(err_count), 64'd0);
`endif

        // partial-lane merge into lower half
        run_write("sel_a", BASE + 32'h30, 32'h1111_1111, 4'hF);
        run_write("sel_b", BASE + 32'h30, 32'hFFFF_FFFF, 4'b0011);
        run_write("sel_c", BASE + 32'h34, 32'h2222_2222, 4'hF);
        check_val("sel_lo_const", 64'(last_wdata[31:0]), 64'h1111_FFFF);

        // reset during RD_MEM aborts the read and drops the pending lower half
        run_write("ra_lo", BASE + 32'h08, 32'hABCD_0123, 4'hF);
        wb_start(1'b0, BASE + 32'h08, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        check_val("ra_rdmem_csb", 64'(csb), 64'd0);
        rst = 1'b1;
        #1;
        check_val("ra_csb_now", 64'(csb), 64'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("ra_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ack_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack) ack_seen++;
        end
        check_val("ra_no_ack", 64'(ack_seen), 64'd0);
        run_write("ra_orph", BASE + 32'h0C, 32'h4444_4444, 4'hF);

        // randomized traffic, including address aliasing
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 9);
            a = BASE + ($urandom_range(0, 15) << 12) + ($urandom_range(0, 7) << 3) + $urandom_range(0, 3);
            if (r < 4) begin
                run_write("rnd_plo", {a[31:3], 1'b0, a[1:0]}, $urandom, 4'($urandom_range(0, 15)));
                run_write("rnd_phi", {a[31:3], 1'b1, a[1:0]}, $urandom, 4'($urandom_range(0, 15)));
            end else if (r < 6) begin
                run_write("rnd_lo", {a[31:3], 1'b0, a[1:0]}, $urandom, 4'($urandom_range(0, 15)));
            end else if (r < 8) begin
                run_write("rnd_hi", {a[31:3], 1'b1, a[1:0]}, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                run_read("rnd_rd", a);
            end
        end
        for (int i = 0; i < 8; i++)
            check_val("mem_final", sram[i], exp_mem[i]);
`ifdef WBS_ERR_CNT_EN
        check_val("err_final", 64'(err_count), 64'(err_m));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wbs_wide_mem_bridge.md
Name: wbs_wide_mem_bridge

Overview:
- Wishbone slave that sits between the Caravel Wishbone bus and one 64-bit-wide single-port SRAM (leaf, query or best-array memory).
- Writes: assembles two 32-bit bus writes (lower half at offset +0, upper half at offset +4) into one 64-bit SRAM write.
- Reads: fetch the 64-bit word and return the addressed 32-bit half.
- One instance per memory region. The core's FSM owns the SRAM while busy; the bridge defers to it through a grant input.

Parameters:
- BASE_ADDR, 32'h3002_0000, region base address; the hit test is (wbs_adr_i & ADDR_MASK) == BASE_ADDR.
- ADDR_MASK, 32'hFFFF_0000, region decode mask.
- MEM_ADDR_WIDTH, 9, SRAM word-address width (512 entries = 64 leaves x 8 patches).
- MEM_DATA_WIDTH, 64, SRAM data width; fixed at 64.

Ports:
- wb_clk_i  in  1  bus and SRAM clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte-lane selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid while ack is high.
- mem_grant_i  in  1  1 = bridge may drive the SRAM.
- mem_csb_o  out  1  SRAM chip select, active-low.
- mem_web_o  out  1  SRAM write enable, active-low.
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM word address.
- mem_wdata_o  out  64  SRAM write data.
- mem_rdata_i  in  64  SRAM read data, valid one cycle after a read select.

Behaviour:
- Reset (asynchronous, wb_rst_i=1) forces these values:
  - wbs_ack_o=0, wbs_dat_o=0
  - mem_csb_o=1, mem_web_o=1, mem_addr_o=0, mem_wdata_o=0
  - lo_hold=0, hi_hold=0, lo_valid=0, lo_idx=0
  - FSM=IDLE
- Reset mid-transaction aborts it with no ack and no SRAM access after reset asserts.
- Request condition: wbs_cyc_i & wbs_stb_i & hit, sampled on the rising edge in IDLE only.
- Non-hit requests are ignored: no ack, no state change.
- Address decode from offset = wbs_adr_i - BASE_ADDR:
  - half = offset[2]
  - idx = offset[MEM_ADDR_WIDTH+2:3]
  - offset[1:0] and the higher offset bits are ignored (aliasing).
- FSM states: IDLE, WR_MEM, RD_MEM, RD_WAIT, ACK.
- Lower write (half=0):
  - Byte lanes with sel=1 are merged into lo_hold; lo_valid=1, lo_idx=idx.
  - IDLE -> ACK.
  - Ack is asserted the cycle after the request is sampled. No SRAM access; grant is not needed.
- Upper write (half=1):
  - Waits in IDLE while mem_grant_i=0.
  - Once granted, selected lanes are merged into hi_hold; IDLE -> WR_MEM.
  - WR_MEM drives for exactly one cycle: csb=0, web=0, addr=idx, wdata={hi_hold, lo_hold}. Then -> ACK. Ack arrives 2 cycles after acceptance.
  - lo_valid is cleared after the write.
- Orphan upper write (lo_valid=0 or lo_idx!=idx):
  - SRAM write is suppressed and hi_hold is updated.
  - Still acked with write latency, so the bus never hangs.
- Read (either half):
  - Waits for grant.
  - RD_MEM: csb=0, web=1, addr=idx.
  - RD_WAIT: captures half ? mem_rdata_i[63:32] : mem_rdata_i[31:0] into wbs_dat_o.
  - ACK. Ack arrives 3 cycles after acceptance.
  - wbs_sel_i is ignored on reads. lo_valid is unaffected.
- ACK state:
  - wbs_ack_o=1 for exactly one cycle, then IDLE.
  - IDLE does not sample during the ack cycle, so there is at least one dead cycle between transactions.
  - Back-to-back requests with stb held high are accepted on the first IDLE edge.
- mem_csb_o is 1 in every state except WR_MEM and RD_MEM.
- Grant dropping after acceptance does not abort the in-flight access. Grant is checked only in IDLE.
- wbs_dat_o holds its last read value until the next read capture.

Optional Feature:
- WBS_ERR_CNT_EN defined:
  - Adds output err_count_o [7:0], reset 0.
  - Increments once per orphan upper write, saturating at 255.
  - A write of any data to offset 0xFFF8 (lower half, idx alias excluded) clears it and is acked in 1 cycle.
- Not defined:
  - Port and counter are absent; orphan writes are still dropped silently.
  - Offset 0xFFF8 decodes as a normal lower write.

Test Plan:
- Write 0x0000_1234 to BASE+0x10, then 0x00AB_CDEF to BASE+0x14 -> one SRAM write, addr=2, wdata=64'h00AB_CDEF_0000_1234. Acks arrive 1 and 2 cycles after acceptance.
- Preload SRAM word 5 = 64'hDEAD_BEEF_CAFE_F00D. Read BASE+0x28 -> wbs_dat_o=0xCAFE_F00D. Read BASE+0x2C -> 0xDEAD_BEEF. Each ack arrives 3 cycles after acceptance.
- mem_grant_i=0, upper write issued -> no ack and csb stays 1 for 10 cycles. Raise grant -> write completes, ack 2 cycles later.
- Upper write to BASE+0x1C without a prior lower write -> ack given, csb stays 1. With WBS_ERR_CNT_EN, err_count_o=1.
- Lower write with sel=4'b0011 and data 0xFFFF_FFFF over lo_hold=0x1111_1111 -> after the upper commit, wdata[31:0]=0x1111_FFFF.
- Assert wb_rst_i during RD_MEM -> ack never asserted, csb=1 immediately, lo_valid=0. The next upper write is treated as an orphan.
